// File: rtl/ssd_scroll_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_scroll_feeder_pkg
//  Brief    : Character-roulette shared types: blank code, char type, scroll FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package ssd_scroll_feeder_pkg;

    localparam logic [4:0] c_BLANK = 5'h1F;

    typedef logic [4:0] char_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SCROLL = 1'b1
    } scroll_state_t;

endpackage
`default_nettype wire

// File: rtl/ssd_scroll_feeder_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_tick_gen
//  Brief    : Free-running divider producing a one-cycle tick every DIV clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module ssd_tick_gen #(
    parameter int SIMULATE = 1,
    parameter int SIM_DIV  = 4,
    parameter int CLK_HZ   = 100_000_000,
    parameter int RATE_HZ  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int c_DIV = (SIMULATE != 0) ? SIM_DIV : (CLK_HZ / RATE_HZ);
    localparam int c_CW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;

    logic [c_CW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == c_CW'(c_DIV - 1));
    assign tick   = w_wrap && !clr;

    always_ff @(posedge clk) begin
        if (reset || clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ssd_scroll_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_scroll_feeder
//  Brief    : Buffers 5-bit character codes and scrolls them right-to-left
//             across digit1/digit0. Define SSD_SCROLL_LOOP_EN to repeat forever.
//  Revision : 1.0 - initial release
// ============================================================================
module ssd_scroll_feeder
    import ssd_scroll_feeder_pkg::*;
#(
    parameter int SIMULATE  = 1,
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCROLL_HZ = 2,
    parameter int SIM_DIV   = 4,
    parameter int DEPTH     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       clear,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [4:0] digit1,
    output logic [4:0] digit0
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    scroll_state_t   r_state;
    scroll_state_t   w_state_nxt;
    char_t           r_buf [DEPTH];
    logic [c_AW:0]   r_count;
    logic [c_AW+1:0] r_rd_ptr;
    char_t           r_digit1;
    char_t           r_digit0;
    logic            r_done;

    logic  w_tick;
    logic  w_start_ok;
    logic  w_wr;
    logic  w_shift;
    logic  w_last_tick;
    logic  w_busy;
    logic  w_ready;
    char_t w_rd_char;

    ssd_tick_gen #(
        .SIMULATE (SIMULATE),
        .SIM_DIV  (SIM_DIV),
        .CLK_HZ   (CLK_HZ),
        .RATE_HZ  (SCROLL_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (w_start_ok || abort),
        .tick  (w_tick)
    );

    assign w_start_ok  = (r_state == IDLE) && start && (r_count != '0) && !abort;
    assign w_wr        = char_valid && w_ready;
    assign w_shift     = (r_state == SCROLL) && w_tick && !r_done && !abort;
    // Tick number count+2 is the one whose rd_ptr equals count+1.
    assign w_last_tick = w_shift && (r_rd_ptr == ({1'b0, r_count} + (c_AW+2)'(1)));
    assign w_rd_char   = ({1'b0, r_count} > r_rd_ptr) ? r_buf[r_rd_ptr[c_AW-1:0]] : c_BLANK;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = SCROLL;
            SCROLL:  if (abort || r_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy  = (r_state == SCROLL);
        w_ready = (r_state == IDLE) && (r_count < (c_AW+1)'(DEPTH)) && !start && !clear;
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_count[c_AW-1:0]] <= char_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_digit1 <= c_BLANK;
            r_digit0 <= c_BLANK;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if ((r_state == IDLE) && clear) begin
                r_count <= '0;
            end else if (w_wr) begin
                r_count <= r_count + (c_AW+1)'(1);
            end

            if (abort || w_start_ok) begin
                r_digit1 <= c_BLANK;
                r_digit0 <= c_BLANK;
                r_rd_ptr <= '0;
            end else if (w_shift) begin
                r_digit1 <= r_digit0;
                r_digit0 <= w_rd_char;
`ifdef SSD_SCROLL_LOOP_EN
                r_rd_ptr <= w_last_tick ? '0 : r_rd_ptr + (c_AW+2)'(1);
`else
                r_rd_ptr <= r_rd_ptr + (c_AW+2)'(1);
                r_done   <= w_last_tick;
`endif
            end
        end
    end

    assign char_ready = w_ready;
    assign busy       = w_busy;
    assign done       = r_done;
    assign digit1     = r_digit1;
    assign digit0     = r_digit0;

endmodule
`default_nettype wire
